// File: rtl/sprshift_wide.sv
// sprshift_wide: per-sprite pixel shifter for the display path.
// Holds sprite position/control and two bitplane data latches written over
// the register bus, arms on a DATA write and, when the beam reaches the
// horizontal start, serialises a 2-bit pixel stream. Supports 16/32/64-bit
// fetches, extended horizontal resolution and a 1x/2x/4x pixel period.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   reset    - synchronous, active-high reset
//   aen      - register write strobe for this sprite
//   address  - register select: 0 POS, 1 CTL, 2 DATA, 3 DATB
//   hpos     - current horizontal beam position
//   data_in  - write data (POS/CTL use bits [7:0])
//   sprdata  - {planeB MSB, planeA MSB}, current pixel
//   attach   - attach flag from CTL bit 7
//   active   - high while undrained pixels are being shown
module sprshift_wide #(
    parameter int unsigned WORDS = 1,
    parameter int unsigned HBITS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aen,
    input  logic [1:0]            address,
    input  logic [HBITS-1:0]      hpos,
    input  logic [16*WORDS-1:0]   data_in,
    output logic [1:0]            sprdata,
    output logic                  attach,
    output logic                  active
);
    localparam int unsigned SW = 16 * WORDS;
    localparam int unsigned CW = $clog2(SW) + 1;

    typedef enum logic [1:0] {
        REG_POS  = 2'd0,
        REG_CTL  = 2'd1,
        REG_DATA = 2'd2,
        REG_DATB = 2'd3
    } reg_sel_t;

    typedef enum logic [1:0] {
        RATE_1X     = 2'd0,
        RATE_2X     = 2'd1,
        RATE_4X     = 2'd2,
        RATE_1X_ALT = 2'd3
    } rate_t;

    logic [HBITS-1:0] hstart;
    logic             armed;
    rate_t            rate;
    rate_t            cur_rate;
    logic [SW-1:0]    datla;
    logic [SW-1:0]    datlb;
    logic [SW-1:0]    shifta;
    logic [SW-1:0]    shiftb;
    logic             load;
    logic             load_del;
    logic [CW-1:0]    cnt;
    logic [1:0]       div;
    logic [1:0]       div_last;
    logic             tick;

    // Register bus: position, control and bitplane latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            hstart <= '0;
            attach <= 1'b0;
            rate   <= RATE_1X;
            armed  <= 1'b0;
            datla  <= '0;
            datlb  <= '0;
        end else if (aen) begin
            case (reg_sel_t'(address))
                REG_POS: hstart[HBITS-1 -: 8] <= data_in[7:0];
                REG_CTL: begin
                    attach              <= data_in[7];
                    rate                <= rate_t'(data_in[6:5]);
                    hstart[HBITS-9:0]   <= data_in[HBITS-9:0];
                    armed               <= 1'b0;
                end
                REG_DATA: begin
                    datla <= data_in;
                    armed <= 1'b1;
                end
                REG_DATB: datlb <= data_in;
                default: ;
            endcase
        end
    end

    // Last divider value of a pixel period for the sprite in flight.
    always_comb begin
        div_last = '0;
        case (cur_rate)
            RATE_2X: div_last = 2'd1;
            RATE_4X: div_last = 2'd3;
            default: div_last = '0;
        endcase
    end

    assign tick = (div == div_last) && (cnt != '0);

    // Trigger pipeline and shifter. A load restarts the shifter even while a
    // sprite is draining, so it takes priority over the pixel tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            load     <= 1'b0;
            load_del <= 1'b0;
            shifta   <= '0;
            shiftb   <= '0;
            cnt      <= '0;
            div      <= '0;
            cur_rate <= RATE_1X;
        end else begin
            load     <= armed && (hpos == hstart);
            load_del <= load;
            if (load_del) begin
                shifta   <= datla;
                shiftb   <= datlb;
                cnt      <= CW'(SW);
                div      <= '0;
                cur_rate <= rate;
            end else if (tick) begin
                shifta <= {shifta[SW-2:0], 1'b0};
                shiftb <= {shiftb[SW-2:0], 1'b0};
                cnt    <= cnt - CW'(1);
                div    <= '0;
            end else if (cnt != '0) begin
                div <= div + 2'd1;
            end else begin
                div <= '0;
            end
        end
    end

    assign sprdata = {shiftb[SW-1], shifta[SW-1]};
    assign active  = (cnt != '0);

endmodule

// File: tb/tb_sprshift_wide.sv
// tb_sprshift_wide: directed self-checking bench for sprshift_wide.
// Three instances cover WORDS=1/HBITS=9, WORDS=4/HBITS=9 and WORDS=1/HBITS=11.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sprshift_wide;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        aen1, aen4, aen11;
    logic [1:0]  address1, address4, address11;
    logic [8:0]  hpos1, hpos4;
    logic [10:0] hpos11;
    logic [15:0] data1, data11;
    logic [63:0] data4;
    logic [1:0]  spr1, spr4, spr11;
    logic        attach1, attach4, attach11;
    logic        active1, active4, active11;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    sprshift_wide #(.WORDS(1), .HBITS(9)) u_w1 (
        .clk(clk), .reset(reset), .aen(aen1), .address(address1), .hpos(hpos1),
        .data_in(data1), .sprdata(spr1), .attach(attach1), .active(active1)
    );
    sprshift_wide #(.WORDS(4), .HBITS(9)) u_w4 (
        .clk(clk), .reset(reset), .aen(aen4), .address(address4), .hpos(hpos4),
        .data_in(data4), .sprdata(spr4), .attach(attach4), .active(active4)
    );
    sprshift_wide #(.WORDS(1), .HBITS(11)) u_h11 (
        .clk(clk), .reset(reset), .aen(aen11), .address(address11), .hpos(hpos11),
        .data_in(data11), .sprdata(spr11), .attach(attach11), .active(active11)
    );

    task automatic wr1(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk); aen1 = 1'b1; address1 = a; data1 = d;
        @(negedge clk); aen1 = 1'b0;
    endtask

    task automatic wr4(input logic [1:0] a, input logic [63:0] d);
        @(negedge clk); aen4 = 1'b1; address4 = a; data4 = d;
        @(negedge clk); aen4 = 1'b0;
    endtask

    task automatic wr11(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk); aen11 = 1'b1; address11 = a; data11 = d;
        @(negedge clk); aen11 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        aen1 = 1'b0; aen4 = 1'b0; aen11 = 1'b0;
        address1 = '0; address4 = '0; address11 = '0;
        data1 = '0; data4 = '0; data11 = '0;
        hpos1 = 9'h100; hpos4 = 9'h100; hpos11 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (spr1 !== 2'b00) begin n_fail++; $display("FAIL reset_spr_w1 got %b expected 00", spr1); end
        n_checks++; if (attach1 !== 1'b0) begin n_fail++; $display("FAIL reset_attach_w1 got %b expected 0", attach1); end
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL reset_active_w1 got %b expected 0", active1); end
        n_checks++; if (spr4 !== 2'b00) begin n_fail++; $display("FAIL reset_spr_w4 got %b expected 00", spr4); end
        n_checks++; if (attach4 !== 1'b0) begin n_fail++; $display("FAIL reset_attach_w4 got %b expected 0", attach4); end
        n_checks++; if (active4 !== 1'b0) begin n_fail++; $display("FAIL reset_active_w4 got %b expected 0", active4); end
        n_checks++; if (spr11 !== 2'b00) begin n_fail++; $display("FAIL reset_spr_h11 got %b expected 00", spr11); end
        n_checks++; if (attach11 !== 1'b0) begin n_fail++; $display("FAIL reset_attach_h11 got %b expected 0", attach11); end
        n_checks++; if (active11 !== 1'b0) begin n_fail++; $display("FAIL reset_active_h11 got %b expected 0", active11); end
    endtask

    // hstart = {0x40, 1} = 0x081; 16 pixels at 1x starting 3 cycles after match.
    task automatic test_basic;
        logic [15:0] ea, eb;
        logic [1:0]  exp_spr;
        logic        exp_act;
        ea = 16'hA5A5; eb = 16'h00FF;
        wr1(2'd0, 16'h0040); wr1(2'd1, 16'h0001); wr1(2'd3, eb); wr1(2'd2, ea);
        for (int h = 'h7d; h <= 'h80; h++) begin
            hpos1 = 9'(h);
            @(negedge clk);
            n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL basic_presweep hpos=%h got %b expected 0", hpos1, active1); end
        end
        hpos1 = 9'h081;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            if (i >= 2 && i < 18) begin exp_spr = {eb[17-i], ea[17-i]}; exp_act = 1'b1; end
            else begin exp_spr = 2'b00; exp_act = 1'b0; end
            n_checks++; if (spr1 !== exp_spr) begin n_fail++; $display("FAIL basic_spr i=%0d got %b expected %b", i, spr1, exp_spr); end
            n_checks++; if (active1 !== exp_act) begin n_fail++; $display("FAIL basic_active i=%0d got %b expected %b", i, active1, exp_act); end
        end
        n_checks++; if (attach1 !== 1'b0) begin n_fail++; $display("FAIL basic_attach got %b expected 0", attach1); end
    endtask

    // 64-bit shifter: only the first and last pixel carry a plane A bit.
    task automatic test_wide;
        logic [1:0] exp_spr;
        logic       exp_act;
        wr4(2'd0, 64'h40); wr4(2'd1, 64'h1); wr4(2'd3, 64'h0);
        wr4(2'd2, 64'h8000_0000_0000_0001);
        hpos4 = 9'h081;
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            if (i == 0) hpos4 = 9'h100;
            exp_spr = {1'b0, (i == 2 || i == 65)};
            exp_act = (i >= 2 && i <= 65);
            n_checks++; if (spr4 !== exp_spr) begin n_fail++; $display("FAIL wide_spr i=%0d got %b expected %b", i, spr4, exp_spr); end
            n_checks++; if (active4 !== exp_act) begin n_fail++; $display("FAIL wide_active i=%0d got %b expected %b", i, active4, exp_act); end
        end
    endtask

    // Rate 2x run with a mid-sprite CTL write of rate 4x (which also disarms).
    task automatic test_rate;
        logic [15:0] ea, eb;
        logic [1:0]  exp_spr;
        logic        exp_act;
        int          k;
        ea = 16'hA5A5; eb = 16'h00FF;
        wr1(2'd1, 16'h0021); wr1(2'd2, ea);
        hpos1 = 9'h081;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            if (i == 6) begin aen1 = 1'b1; address1 = 2'd1; data1 = 16'h0041; end
            if (i == 7) aen1 = 1'b0;
            k = (i - 2) / 2;
            if (i >= 2 && i <= 33) begin exp_spr = {eb[15-k], ea[15-k]}; exp_act = 1'b1; end
            else begin exp_spr = 2'b00; exp_act = 1'b0; end
            n_checks++; if (spr1 !== exp_spr) begin n_fail++; $display("FAIL rate2_spr i=%0d got %b expected %b", i, spr1, exp_spr); end
            n_checks++; if (active1 !== exp_act) begin n_fail++; $display("FAIL rate2_active i=%0d got %b expected %b", i, active1, exp_act); end
        end
        hpos1 = 9'h081;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL rate_disarmed i=%0d got %b expected 0", i, active1); end
        end
        ea = 16'hF00F;
        wr1(2'd2, ea);
        hpos1 = 9'h081;
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            k = (i - 2) / 4;
            if (i >= 2 && i <= 65) begin exp_spr = {eb[15-k], ea[15-k]}; exp_act = 1'b1; end
            else begin exp_spr = 2'b00; exp_act = 1'b0; end
            n_checks++; if (spr1 !== exp_spr) begin n_fail++; $display("FAIL rate4_spr i=%0d got %b expected %b", i, spr1, exp_spr); end
            n_checks++; if (active1 !== exp_act) begin n_fail++; $display("FAIL rate4_active i=%0d got %b expected %b", i, active1, exp_act); end
        end
    endtask

    // Second match 5 cycles after the first shifter load, with new DATA.
    task automatic test_back_to_back;
        logic [15:0] ea, ea2, eb;
        logic [1:0]  exp_spr;
        logic        exp_act;
        ea = 16'hA5A5; ea2 = 16'h1234; eb = 16'h00FF;
        wr1(2'd1, 16'h0001); wr1(2'd2, ea);
        hpos1 = 9'h081;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            if (i == 3) begin aen1 = 1'b1; address1 = 2'd2; data1 = ea2; end
            if (i == 4) aen1 = 1'b0;
            if (i == 6) hpos1 = 9'h081;
            if (i == 7) hpos1 = 9'h100;
            if (i >= 2 && i <= 8) begin exp_spr = {eb[17-i], ea[17-i]}; exp_act = 1'b1; end
            else if (i >= 9 && i <= 24) begin exp_spr = {eb[24-i], ea2[24-i]}; exp_act = 1'b1; end
            else begin exp_spr = 2'b00; exp_act = 1'b0; end
            n_checks++; if (spr1 !== exp_spr) begin n_fail++; $display("FAIL retrig_spr i=%0d got %b expected %b", i, spr1, exp_spr); end
            n_checks++; if (active1 !== exp_act) begin n_fail++; $display("FAIL retrig_active i=%0d got %b expected %b", i, active1, exp_act); end
        end
    endtask

    task automatic test_disarm;
        wr1(2'd1, 16'h0081);
        n_checks++; if (attach1 !== 1'b1) begin n_fail++; $display("FAIL attach_set got %b expected 1", attach1); end
        // Armed by DATA, then disarmed by CTL: the match must not load.
        wr1(2'd2, 16'h5555); wr1(2'd1, 16'h0081);
        hpos1 = 9'h081;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            n_checks++; if (spr1 !== 2'b00) begin n_fail++; $display("FAIL ctl_disarm_spr i=%0d got %b expected 00", i, spr1); end
            n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL ctl_disarm_active i=%0d got %b expected 0", i, active1); end
        end
        // DATB alone must not arm.
        wr1(2'd3, 16'hAAAA);
        hpos1 = 9'h081;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL datb_noarm_active i=%0d got %b expected 0", i, active1); end
        end
        // CTL write on the match cycle: that load still completes.
        wr1(2'd2, 16'hFFFF);
        hpos1 = 9'h081; aen1 = 1'b1; address1 = 2'd1; data1 = 16'h0001;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i == 0) begin hpos1 = 9'h100; aen1 = 1'b0; end
            if (i == 2) begin
                n_checks++; if (spr1 !== 2'b11) begin n_fail++; $display("FAIL ctl_on_match_spr got %b expected 11", spr1); end
                n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL ctl_on_match_active got %b expected 1", active1); end
                n_checks++; if (attach1 !== 1'b0) begin n_fail++; $display("FAIL attach_clear got %b expected 0", attach1); end
            end
            if (i == 20) begin
                n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL ctl_on_match_end got %b expected 0", active1); end
            end
        end
        hpos1 = 9'h081;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) hpos1 = 9'h100;
            n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL post_ctl_disarm i=%0d got %b expected 0", i, active1); end
        end
    endtask

    // HBITS=11: hstart = {0xFF, 3'b101} = 0x7FD; reset mid-sprite.
    task automatic test_hbits11;
        logic [10:0] misses [6];
        logic [1:0]  exp_spr;
        logic        exp_act;
        misses = '{11'h7FC, 11'h7FE, 11'h3FD, 11'h7F5, 11'h6FD, 11'h7DD};
        wr11(2'd0, 16'h00FF); wr11(2'd1, 16'h0005); wr11(2'd3, 16'h0000); wr11(2'd2, 16'hFFFF);
        for (int j = 0; j < 9; j++) begin
            hpos11 = (j < 6) ? misses[j] : 11'h000;
            @(negedge clk);
            n_checks++; if (active11 !== 1'b0) begin n_fail++; $display("FAIL h11_miss j=%0d got %b expected 0", j, active11); end
        end
        hpos11 = 11'h7FD;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) hpos11 = 11'h000;
            if (i == 5) reset = 1'b1;
            if (i == 6) reset = 1'b0;
            exp_spr = (i >= 2 && i <= 5) ? 2'b01 : 2'b00;
            exp_act = (i >= 2 && i <= 5);
            n_checks++; if (spr11 !== exp_spr) begin n_fail++; $display("FAIL h11_spr i=%0d got %b expected %b", i, spr11, exp_spr); end
            n_checks++; if (active11 !== exp_act) begin n_fail++; $display("FAIL h11_active i=%0d got %b expected %b", i, active11, exp_act); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_rate();
        test_back_to_back();
        test_disarm();
        test_hbits11();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
